// File: rtl/wdg_multi_core.sv
// Multi-channel watchdog: CH key-fed down-counters on a shared prescaler, with warn/expire
// stages and a stretched reset request. Define WDG_WINDOW_EN to expire channels fed too early.
module wdg_multi_core #(
   parameter int unsigned      CH       = 4,
   parameter int unsigned      CNT_W    = 16,
   parameter int unsigned      PSC_W    = 8,
   parameter int unsigned      KEY_W    = 16,
   parameter logic [KEY_W-1:0] FEED_KEY = 16'h5A5A,
   parameter int unsigned      RST_LEN  = 16,
   localparam int unsigned     FCH_W    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [CH-1:0]       en_i,
   input  logic [PSC_W-1:0]    psc_i,
   input  logic [CH*CNT_W-1:0] load_i,
   input  logic [CH*CNT_W-1:0] warn_i,
   input  logic [CH*CNT_W-1:0] win_i,
   input  logic                feed_valid_i,
   input  logic [FCH_W-1:0]    feed_ch_i,
   input  logic [KEY_W-1:0]    feed_key_i,
   input  logic [CH-1:0]       clr_i,
   output logic                feed_ack_o,
   output logic                bad_key_o,
   output logic [CH-1:0]       warn_o,
   output logic [CH-1:0]       expired_o,
   output logic                rst_req_o,
   output logic [CH*CNT_W-1:0] cnt_o
);

   localparam int unsigned RC_W = $clog2(RST_LEN + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WARN = 2'd2;
   localparam logic [1:0] ST_EXP  = 2'd3;

   logic [PSC_W-1:0] psc_q;
   logic [1:0]       st_q   [CH];
   logic [1:0]       st_d   [CH];
   logic [CNT_W-1:0] cnt_q  [CH];
   logic [CNT_W-1:0] cnt_d  [CH];
   logic [CNT_W-1:0] ld_w   [CH];
   logic [CNT_W-1:0] warn_w [CH];
   logic [CH-1:0]    hit_w;
   logic [CH-1:0]    early_w;
   logic [RC_W-1:0]  rst_ctr_q;
   logic             any_en;
   logic             tick;
   logic             key_ok;
   logic             ack_d;
   logic             exp_evt;
   logic             feed_ack_q;
   logic             bad_key_q;

   assign any_en = |en_i;
   assign tick   = any_en && (psc_q == psc_i);
   assign key_ok = (feed_key_i == FEED_KEY);

   for (genvar c = 0; c < CH; c++) begin : g_ch
      assign ld_w[c]                 = load_i[c*CNT_W +: CNT_W];
      assign warn_w[c]               = warn_i[c*CNT_W +: CNT_W];
      assign hit_w[c]                = feed_valid_i && key_ok && (feed_ch_i == FCH_W'(c));
      assign warn_o[c]               = (st_q[c] == ST_WARN);
      assign expired_o[c]            = (st_q[c] == ST_EXP);
      assign cnt_o[c*CNT_W +: CNT_W] = cnt_q[c];
   end

`ifdef WDG_WINDOW_EN
   for (genvar c = 0; c < CH; c++) begin : g_win
      assign early_w[c] = (cnt_q[c] > win_i[c*CNT_W +: CNT_W]);
   end
`else
   logic unused_win;
   assign unused_win = ^win_i;
   for (genvar c = 0; c < CH; c++) begin : g_win
      assign early_w[c] = 1'b0;
   end
`endif

   // Disable wins over everything; a feed wins over a tick in the same cycle.
   always_comb begin
      ack_d   = 1'b0;
      exp_evt = 1'b0;
      for (int c = 0; c < CH; c++) begin
         st_d[c]  = st_q[c];
         cnt_d[c] = cnt_q[c];
         if (!en_i[c]) begin
            st_d[c]  = ST_IDLE;
            cnt_d[c] = ld_w[c];
         end else begin
            case (st_q[c])
               ST_IDLE: begin
                  st_d[c]  = ST_RUN;
                  cnt_d[c] = ld_w[c];
               end
               ST_RUN, ST_WARN: begin
                  if (hit_w[c]) begin
                     if (early_w[c]) begin
                        st_d[c] = ST_EXP;
                        exp_evt = 1'b1;
                     end else begin
                        st_d[c]  = ST_RUN;
                        cnt_d[c] = ld_w[c];
                        ack_d    = 1'b1;
                     end
                  end else if (tick) begin
                     if (cnt_q[c] == '0) begin
                        st_d[c] = ST_EXP;
                        exp_evt = 1'b1;
                     end else begin
                        cnt_d[c] = cnt_q[c] - CNT_W'(1);
                        if ((st_q[c] == ST_RUN) && (cnt_d[c] <= warn_w[c])) begin
                           st_d[c] = ST_WARN;
                        end
                     end
                  end
               end
               default: begin
                  if (clr_i[c]) begin
                     st_d[c]  = ST_RUN;
                     cnt_d[c] = ld_w[c];
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         psc_q      <= '0;
         feed_ack_q <= 1'b0;
         bad_key_q  <= 1'b0;
         rst_ctr_q  <= '0;
         for (int c = 0; c < CH; c++) begin
            st_q[c]  <= ST_IDLE;
            cnt_q[c] <= '0;
         end
      end else begin
         // A compare value lowered below the running count wraps on the next clock.
         if (any_en) begin
            psc_q <= (psc_q >= psc_i) ? '0 : psc_q + PSC_W'(1);
         end
         feed_ack_q <= ack_d;
         bad_key_q  <= feed_valid_i && !key_ok;
         if (exp_evt) begin
            rst_ctr_q <= RC_W'(RST_LEN);
         end else if (rst_ctr_q != '0) begin
            rst_ctr_q <= rst_ctr_q - RC_W'(1);
         end
         for (int c = 0; c < CH; c++) begin
            st_q[c]  <= st_d[c];
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   assign feed_ack_o = feed_ack_q;
   assign bad_key_o  = bad_key_q;
   assign rst_req_o  = (rst_ctr_q != '0);

endmodule

// File: tb/tb_wdg_multi_core.sv
// Bench for wdg_multi_core: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a channel-level reference model.
module tb_wdg_multi_core;

   localparam int CH      = 4;
   localparam int CNT_W   = 16;
   localparam int PSC_W   = 8;
   localparam int KEY_W   = 16;
   localparam int RST_LEN = 16;
   localparam logic [KEY_W-1:0] KEY = 16'h5A5A;
`ifdef WDG_WINDOW_EN
   localparam bit WIN_EN = 1'b1;
`else
   localparam bit WIN_EN = 1'b0;
`endif
   localparam int M_OFF  = 0;
   localparam int M_CNT  = 1;
   localparam int M_DEAD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [CH-1:0]       en;
   logic [CH-1:0]       clr;
   logic [PSC_W-1:0]    psc;
   logic [CNT_W-1:0]    ld [CH];
   logic [CNT_W-1:0]    wr [CH];
   logic [CNT_W-1:0]    wn [CH];
   logic [CH*CNT_W-1:0] load_b, warn_b, win_b;
   logic                fv;
   logic [1:0]          fch;
   logic [KEY_W-1:0]    fkey;
   logic                feed_ack, bad_key, rst_req;
   logic [CH-1:0]       warn_v, exp_v;
   logic [CH*CNT_W-1:0] cnt_v;

   for (genvar c = 0; c < CH; c++) begin : g_pack
      assign load_b[c*CNT_W +: CNT_W] = ld[c];
      assign warn_b[c*CNT_W +: CNT_W] = wr[c];
      assign win_b[c*CNT_W +: CNT_W]  = wn[c];
   end

   wdg_multi_core dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .psc_i        (psc),
      .load_i       (load_b),
      .warn_i       (warn_b),
      .win_i        (win_b),
      .feed_valid_i (fv),
      .feed_ch_i    (fch),
      .feed_key_i   (fkey),
      .clr_i        (clr),
      .feed_ack_o   (feed_ack),
      .bad_key_o    (bad_key),
      .warn_o       (warn_v),
      .expired_o    (exp_v),
      .rst_req_o    (rst_req),
      .cnt_o        (cnt_v)
   );

   // Reference model: channel mode, remaining count and a sticky "warned" flag.
   int m_mode [CH];
   bit m_wf   [CH];
   int m_cnt  [CH];
   int m_psc;
   int m_rst;
   bit m_ack;
   bit m_bad;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit any, tk, ok, ack, ev;
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            m_mode[c] = M_OFF; m_wf[c] = 1'b0; m_cnt[c] = 0;
         end
         m_psc = 0; m_rst = 0; m_ack = 1'b0; m_bad = 1'b0;
         return;
      end
      any = |en;
      tk  = any && (m_psc == int'(psc));
      ok  = (fkey == KEY);
      ack = 1'b0;
      ev  = 1'b0;
      for (int c = 0; c < CH; c++) begin
         bit fed;
         fed = fv && ok && (int'(fch) == c);
         if (!en[c]) begin
            m_mode[c] = M_OFF; m_wf[c] = 1'b0; m_cnt[c] = int'(ld[c]);
         end else if (m_mode[c] == M_OFF) begin
            m_mode[c] = M_CNT; m_wf[c] = 1'b0; m_cnt[c] = int'(ld[c]);
         end else if (m_mode[c] == M_CNT) begin
            if (fed && WIN_EN && (m_cnt[c] > int'(wn[c]))) begin
               m_mode[c] = M_DEAD; m_wf[c] = 1'b0; ev = 1'b1;
            end else if (fed) begin
               m_cnt[c] = int'(ld[c]); m_wf[c] = 1'b0; ack = 1'b1;
            end else if (tk) begin
               if (m_cnt[c] == 0) begin
                  m_mode[c] = M_DEAD; m_wf[c] = 1'b0; ev = 1'b1;
               end else begin
                  m_cnt[c] = m_cnt[c] - 1;
                  if (m_cnt[c] <= int'(wr[c])) m_wf[c] = 1'b1;
               end
            end
         end else if (clr[c]) begin
            m_mode[c] = M_CNT; m_wf[c] = 1'b0; m_cnt[c] = int'(ld[c]);
         end
      end
      if (any) m_psc = (m_psc >= int'(psc)) ? 0 : m_psc + 1;
      m_ack = ack;
      m_bad = fv && !ok;
      if (ev) m_rst = RST_LEN;
      else if (m_rst > 0) m_rst = m_rst - 1;
   endtask

   task automatic compare_all();
      logic [CH-1:0]       ew, ee;
      logic [CH*CNT_W-1:0] ec;
      for (int c = 0; c < CH; c++) begin
         ew[c] = (m_mode[c] == M_CNT) && m_wf[c];
         ee[c] = (m_mode[c] == M_DEAD);
         ec[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
      end
      chk("warn_o", 64'(warn_v), 64'(ew));
      chk("expired_o", 64'(exp_v), 64'(ee));
      chk("cnt_o", 64'(cnt_v), 64'(ec));
      chk("feed_ack_o", 64'(feed_ack), 64'(m_ack));
      chk("bad_key_o", 64'(bad_key), 64'(m_bad));
      chk("rst_req_o", 64'(rst_req), 64'(m_rst != 0));
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         model_step();
         @(posedge clk);
         #1;
         compare_all();
      end
   endtask

   task automatic feed(input logic [1:0] ch, input logic [KEY_W-1:0] key);
      fv = 1'b1; fch = ch; fkey = key;
      cyc(1);
      fv = 1'b0;
   endtask

   initial begin
      int hi;
      rst = 1'b1; en = '0; clr = '0; psc = '0; fv = 1'b0; fch = '0; fkey = '0;
      ld[0] = 16'd10; ld[1] = 16'd20; ld[2] = 16'd6; ld[3] = 16'd0;
      wr[0] = 16'd3;  wr[1] = 16'd5;  wr[2] = 16'd2; wr[3] = 16'd0;
      for (int c = 0; c < CH; c++) wn[c] = 16'd5;

      // Reset state
      cyc(2);
      chk("reset_cnt", 64'(cnt_v), 64'd0);
      chk("reset_req", 64'(rst_req), 64'd0);
      rst = 1'b0;
      cyc(1);

      // Free-running ch0: warn after 7 ticks, expiry after 11, 16-cycle request
      en = 4'b0001;
      cyc(1);
      chk("a_load", 64'(cnt_v[15:0]), 64'd10);
      cyc(6);
      chk("a_nowarn", 64'(warn_v[0]), 64'd0);
      cyc(1);
      chk("a_warn", 64'(warn_v[0]), 64'd1);
      cyc(3);
      chk("a_noexp", 64'(exp_v[0]), 64'd0);
      cyc(1);
      chk("a_exp", 64'(exp_v[0]), 64'd1);
      chk("a_req", 64'(rst_req), 64'd1);
      hi = 1;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (rst_req) hi++;
      end
      chk("a_pulse_len", 64'(hi), 64'd16);
      en = 4'b0000;
      cyc(1);
      chk("a_idle", 64'(exp_v), 64'd0);

      // Good feed at cnt=5
      en = 4'b0001;
      cyc(6);
      chk("b_cnt5", 64'(cnt_v[15:0]), 64'd5);
      feed(2'd0, KEY);
      chk("b_ack", 64'(feed_ack), 64'd1);
      chk("b_reload", 64'(cnt_v[15:0]), 64'd10);
      cyc(1);
      chk("b_ack_pulse", 64'(feed_ack), 64'd0);

      // Bad key on ch1; ch1 still expires on schedule
      en = 4'b0011;
      cyc(1);
      feed(2'd1, 16'h1234);
      chk("c_badkey", 64'(bad_key), 64'd1);
      chk("c_noack", 64'(feed_ack), 64'd0);
      chk("c_cnt", 64'(cnt_v[31:16]), 64'd19);
      cyc(19);
      chk("c_noexp", 64'(exp_v[1]), 64'd0);
      cyc(1);
      chk("c_exp", 64'(exp_v[1]), 64'd1);
      en = 4'b0000;
      cyc(1);

      // psc=3: feed on a tick cycle reloads to load, then one decrement per 4 clocks
      psc = 8'd3;
      en = 4'b0001;
      cyc(1);
      for (int i = 0; i < 8; i++) begin
         if (m_psc == 3) break;
         cyc(1);
      end
      feed(2'd0, KEY);
      chk("d_feed_tick", 64'(cnt_v[15:0]), 64'd10);
      cyc(3);
      chk("d_hold", 64'(cnt_v[15:0]), 64'd10);
      cyc(1);
      chk("d_dec", 64'(cnt_v[15:0]), 64'd9);

      // ch2 expiry during ch0's pulse extends it; clr_i; reset mid-pulse
      en = 4'b0000; psc = 8'd0;
      ld[0] = 16'd2; wr[0] = 16'd0; ld[2] = 16'd5; wr[2] = 16'd0;
      cyc(1);
      en = 4'b0101;
      cyc(3);
      cyc(1);
      chk("f_req", 64'(rst_req), 64'd1);
      cyc(16);
      chk("f_extend", 64'(rst_req), 64'd1);
      chk("f_both_exp", 64'(exp_v), 64'b0101);
      clr = 4'b0100;
      cyc(1);
      clr = 4'b0000;
      chk("f_clr", 64'(exp_v), 64'b0001);
      chk("f_clr_cnt", 64'(cnt_v[47:32]), 64'd5);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("f_rst_req", 64'(rst_req), 64'd0);
      chk("f_rst_exp", 64'(exp_v), 64'd0);
      chk("f_rst_cnt", 64'(cnt_v), 64'd0);

      // Boundaries: load=0 expires on first tick, warn>=load warns on first tick
      en = 4'b0000;
      ld[3] = 16'd0; wr[3] = 16'd0; ld[1] = 16'd4; wr[1] = 16'd7;
      cyc(1);
      en = 4'b1010;
      cyc(2);
      chk("h_load0", 64'(exp_v), 64'b1000);
      chk("h_warnge", 64'(warn_v), 64'b0010);

`ifdef WDG_WINDOW_EN
      en = 4'b0000;
      ld[0] = 16'd10; wr[0] = 16'd3; wn[0] = 16'd5;
      cyc(1);
      en = 4'b0001;
      cyc(3);
      feed(2'd0, KEY);
      chk("e_early_exp", 64'(exp_v[0]), 64'd1);
      chk("e_early_noack", 64'(feed_ack), 64'd0);
      clr = 4'b0001;
      cyc(1);
      clr = 4'b0000;
      cyc(6);
      feed(2'd0, KEY);
      chk("e_ok_ack", 64'(feed_ack), 64'd1);
      chk("e_ok_cnt", 64'(cnt_v[15:0]), 64'd10);
`endif

      // Randomized traffic against the model
      en = 4'b1111;
      for (int c = 0; c < CH; c++) begin
         ld[c] = CNT_W'($urandom_range(0, 15));
         wr[c] = CNT_W'($urandom_range(0, 15));
         wn[c] = CNT_W'($urandom_range(0, 15));
      end
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
            if ($urandom_range(0, 49) == 0) ld[c] = CNT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) wr[c] = CNT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) wn[c] = CNT_W'($urandom_range(0, 15));
            clr[c] = ($urandom_range(0, 9) == 0);
         end
         if ($urandom_range(0, 49) == 0) psc = PSC_W'($urandom_range(0, 3));
         fv   = ($urandom_range(0, 5) == 0);
         fch  = 2'($urandom_range(0, 3));
         fkey = ($urandom_range(0, 3) == 0) ? KEY_W'($urandom) : KEY;
         cyc(1);
      end
      rst = 1'b0; fv = 1'b0; clr = '0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
